// File: rtl/a2owb_mem_responder_pkg.sv
// a2owb_mem_responder_pkg: shared bus widths and responder FSM state encoding.
package a2owb_mem_responder_pkg;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } wb_state_e;
endpackage

// File: rtl/a2owb_mem_responder_sram_1rw.sv
// a2owb_mem_responder_sram_1rw: single-port SRAM, byte-enabled sync write, registered read.
module a2owb_mem_responder_sram_1rw
  import a2owb_mem_responder_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic                clk,
  input  logic                en,
  input  logic                we,
  input  logic [WB_SEL_W-1:0] sel,
  input  logic [AW-1:0]       idx,
  input  logic [WB_DAT_W-1:0] wdata,
  output logic [WB_DAT_W-1:0] rdata
);
  logic [WB_DAT_W-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (en && we)
      for (int i = 0; i < WB_SEL_W; i++)
        if (sel[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    if (en && !we) rdata <= mem[idx];
  end
endmodule

// File: rtl/a2owb_mem_responder.sv
// a2owb_mem_responder: Wishbone B4 classic responder backed by byte-writable SRAM with wait states.
module a2owb_mem_responder
  import a2owb_mem_responder_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h1000_0000,
  parameter int          MEM_WORDS   = 1024,
  parameter int          WAIT_STATES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_cyc,
  input  logic                wb_stb,
  input  logic [31:0]         wb_adr,
  input  logic                wb_we,
  input  logic [WB_SEL_W-1:0] wb_sel,
  input  logic [WB_DAT_W-1:0] wb_datw,
  output logic                wb_ack,
  output logic [WB_DAT_W-1:0] wb_datr,
  output logic                wb_miss,
  output logic [15:0]         rd_count,
  output logic [15:0]         wr_count
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [31:0] WIN_MASK = 32'(MEM_WORDS * 4 - 1);
  localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
  wb_state_e state, state_nx;
  logic [3:0] cnt;
  logic q_we, miss_seen;
  logic [WB_SEL_W-1:0] q_sel;
  logic [AW-1:0] q_idx;
  logic [WB_DAT_W-1:0] q_dat, rdata;
  logic req, hit, start, enter_ack, miss_now, m_we;
  assign req       = wb_cyc & wb_stb;
  assign hit       = (wb_adr & ~WIN_MASK) == ADDR_BASE;
  assign start     = state == ST_IDLE && req && hit;
  assign miss_now  = state == ST_IDLE && req && !hit && !miss_seen;
  assign enter_ack = state != ST_ACK && state_nx == ST_ACK;
  // With zero wait states the access happens on the capture edge, so use the live bus.
  assign m_we      = start ? wb_we : q_we;
  a2owb_mem_responder_sram_1rw #(.AW(AW)) u_sram (
    .clk  (clk),
    .en   (enter_ack & rst),
    .we   (m_we),
    .sel  (start ? wb_sel : q_sel),
    .idx  (start ? wb_adr[2 +: AW] : q_idx),
    .wdata(start ? wb_datw : q_dat),
    .rdata(rdata)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end
  always_comb begin
    state_nx = ST_IDLE;
    unique case (state)
      ST_IDLE: state_nx = start ? (WAIT_STATES == 0 ? ST_ACK : ST_WAIT) : ST_IDLE;
      ST_WAIT: state_nx = !wb_cyc ? ST_IDLE : (cnt == 4'd0 ? ST_ACK : ST_WAIT);
      default: state_nx = ST_IDLE;
    endcase
  end
  always_comb begin
    wb_ack  = state == ST_ACK;
    wb_datr = wb_ack ? rdata : '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      q_we      <= 1'b0;
      q_sel     <= '0;
      q_idx     <= '0;
      q_dat     <= '0;
      wb_miss   <= 1'b0;
      miss_seen <= 1'b0;
      rd_count  <= '0;
      wr_count  <= '0;
    end else begin
      if (start) begin
        q_we  <= wb_we;
        q_sel <= wb_sel;
        q_idx <= wb_adr[2 +: AW];
        q_dat <= wb_datw;
        cnt   <= CNT_INIT;
      end else if (state == ST_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      wb_miss   <= miss_now;
      miss_seen <= req & (miss_seen | miss_now);
      if (enter_ack &&  m_we) wr_count <= wr_count + 16'd1;
      if (enter_ack && !m_we) rd_count <= rd_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_a2owb_mem_responder.sv
// tb_a2owb_mem_responder: scoreboard bench over three responders with 0, 1 and 3 wait states.
module tb_a2owb_mem_responder;
  logic clk = 1'b0, rst = 1'b0;
  logic wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [31:0] wb_adr = '0, wb_datw = '0;
  logic [3:0] wb_sel = '0;
  int tgt = 0;
  logic [2:0] cyc_v;
  logic ack [3];
  logic miss [3];
  logic [31:0] datr [3];
  logic [15:0] rdc [3], wrc [3];
  int ws [3] = '{0, 1, 3};
  int exp_rd [3] = '{0, 0, 0};
  int exp_wr [3] = '{0, 0, 0};
  logic [31:0] model [int];
  logic [31:0] sb [$];
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  assign cyc_v[0] = wb_cyc & (tgt == 0);
  assign cyc_v[1] = wb_cyc & (tgt == 1);
  assign cyc_v[2] = wb_cyc & (tgt == 2);
  a2owb_mem_responder #(.WAIT_STATES(0)) u_ws0 (.clk(clk), .rst(rst), .wb_cyc(cyc_v[0]), .wb_stb(wb_stb),
    .wb_adr(wb_adr), .wb_we(wb_we), .wb_sel(wb_sel), .wb_datw(wb_datw), .wb_ack(ack[0]), .wb_datr(datr[0]),
    .wb_miss(miss[0]), .rd_count(rdc[0]), .wr_count(wrc[0]));
  a2owb_mem_responder #(.WAIT_STATES(1)) u_ws1 (.clk(clk), .rst(rst), .wb_cyc(cyc_v[1]), .wb_stb(wb_stb),
    .wb_adr(wb_adr), .wb_we(wb_we), .wb_sel(wb_sel), .wb_datw(wb_datw), .wb_ack(ack[1]), .wb_datr(datr[1]),
    .wb_miss(miss[1]), .rd_count(rdc[1]), .wr_count(wrc[1]));
  a2owb_mem_responder #(.WAIT_STATES(3)) u_ws3 (.clk(clk), .rst(rst), .wb_cyc(cyc_v[2]), .wb_stb(wb_stb),
    .wb_adr(wb_adr), .wb_we(wb_we), .wb_sel(wb_sel), .wb_datw(wb_datw), .wb_ack(ack[2]), .wb_datr(datr[2]),
    .wb_miss(miss[2]), .rd_count(rdc[2]), .wr_count(wrc[2]));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    if (obs === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, want);
  endtask
  task automatic chk_counts(input int t);
    chk($sformatf("rd_count%0d", t), 32'(rdc[t]), 32'(exp_rd[t]));
    chk($sformatf("wr_count%0d", t), 32'(wrc[t]), 32'(exp_wr[t]));
  endtask
  task automatic drive(input int t, input logic we, input logic [31:0] adr, input logic [3:0] sel,
                       input logic [31:0] dat);
    int key;
    logic [31:0] cur;
    key = t * 100000 + int'(adr[11:2]);
    if (adr[31:12] == 20'h10000) begin
      if (we) begin
        cur = model.exists(key) ? model[key] : 32'h0;
        for (int i = 0; i < 4; i++) if (sel[i]) cur[8*i +: 8] = dat[8*i +: 8];
        model[key] = cur;
      end else begin
        sb.push_back(model.exists(key) ? model[key] : 32'h0);
      end
    end
    tgt = t; wb_we = we; wb_adr = adr; wb_sel = sel; wb_datw = dat; wb_cyc = 1'b1; wb_stb = 1'b1;
  endtask
  task automatic xfer(input int t, input logic we, input logic [31:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat);
    int lat;
    logic [31:0] want;
    drive(t, we, adr, sel, dat);
    lat = 0;
    do begin
      @(posedge clk); lat++; @(negedge clk);
    end while (!ack[t] && lat < 40);
    chk($sformatf("latency%0d", t), 32'(lat), 32'(ws[t] + 1));
    if (!we) begin
      want = sb.pop_front();
      chk($sformatf("rdata%0d@%h", t, adr), datr[t], want);
    end
    if (we) exp_wr[t]++; else exp_rd[t]++;
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(negedge clk);
    chk("ack_one_cycle", 32'(ack[t]), 32'h0);
    chk("datr_zero_after", datr[t], 32'h0);
    chk_counts(t);
  endtask
  initial begin
    int n_miss, n_ack;
    logic [4:0] pat;
    tgt = 1; wb_cyc = 1'b1; wb_stb = 1'b1; wb_adr = 32'h1000_0004;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ack", 32'(ack[1]), 32'h0);
      chk("rst_datr", datr[1], 32'h0);
      chk("rst_miss", 32'(miss[1]), 32'h0);
    end
    for (int t = 0; t < 3; t++) chk_counts(t);
    wb_cyc = 1'b0; wb_stb = 1'b0; rst = 1'b1;
    n_ack = 0;
    repeat (3) begin @(negedge clk); n_ack += int'(ack[1]); end
    chk("no_spurious_ack", 32'(n_ack), 32'h0);
    xfer(1, 1'b1, 32'h1000_0004, 4'hF, 32'hA5A5_1234);
    xfer(1, 1'b0, 32'h1000_0004, 4'hF, 32'h0);
    xfer(1, 1'b1, 32'h1000_0004, 4'b0100, 32'h00CC_0000);
    xfer(1, 1'b0, 32'h1000_0004, 4'hF, 32'h0);
    xfer(1, 1'b1, 32'h1000_0010, 4'b0000, 32'hFFFF_FFFF);
    xfer(1, 1'b0, 32'h1000_0010, 4'hF, 32'h0);
    xfer(1, 1'b1, 32'h1000_0FFC, 4'b1001, 32'h8765_4321);
    xfer(1, 1'b0, 32'h1000_0FFF, 4'hF, 32'h0);
    xfer(2, 1'b1, 32'h1000_0008, 4'hF, 32'h1111_2222);
    tgt = 2; wb_we = 1'b1; wb_adr = 32'h1000_0008; wb_sel = 4'hF; wb_datw = 32'hFFFF_FFFF;
    wb_cyc = 1'b1; wb_stb = 1'b1;
    @(posedge clk); @(negedge clk);
    n_ack = int'(ack[2]);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    repeat (6) begin @(negedge clk); n_ack += int'(ack[2]); end
    chk("abort_no_ack", 32'(n_ack), 32'h0);
    chk_counts(2);
    xfer(2, 1'b0, 32'h1000_0008, 4'hF, 32'h0);
    drive(1, 1'b0, 32'h2000_0000, 4'hF, 32'h0);
    n_miss = 0; n_ack = 0;
    repeat (5) begin
      @(posedge clk); @(negedge clk);
      n_miss += int'(miss[1]); n_ack += int'(ack[1]);
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(negedge clk); n_miss += int'(miss[1]); n_ack += int'(ack[1]);
    chk("miss_pulses", 32'(n_miss), 32'h1);
    chk("miss_no_ack", 32'(n_ack), 32'h0);
    chk_counts(1);
    xfer(0, 1'b1, 32'h1000_0004, 4'hF, 32'h5555_AAAA);
    drive(0, 1'b0, 32'h1000_0004, 4'hF, 32'h0);
    sb.push_back(model[int'(32'h1)]);
    sb.push_back(model[int'(32'h1)]);
    pat = '0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      pat = {pat[3:0], ack[0]};
      if (ack[0] && sb.size() > 0) chk("b2b_rdata", datr[0], sb.pop_front());
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    chk("b2b_pattern", 32'(pat), 32'h15);
    chk("b2b_sb_drained", 32'(sb.size()), 32'h0);
    sb.delete();
    exp_rd[0] += 3;
    @(negedge clk);
    chk_counts(0);
    xfer(2, 1'b1, 32'h1000_000C, 4'hF, 32'hDEAD_BEEF);
    tgt = 2; wb_we = 1'b1; wb_adr = 32'h1000_000C; wb_sel = 4'hF; wb_datw = 32'h0;
    wb_cyc = 1'b1; wb_stb = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    n_ack = 0;
    repeat (4) begin #1; n_ack += int'(ack[2]); @(negedge clk); end
    chk("rst_mid_no_ack", 32'(n_ack), 32'h0);
    for (int t = 0; t < 3; t++) begin exp_rd[t] = 0; exp_wr[t] = 0; chk_counts(t); end
    wb_cyc = 1'b0; wb_stb = 1'b0; rst = 1'b1;
    @(negedge clk);
    xfer(2, 1'b0, 32'h1000_000C, 4'hF, 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
